display_scheduler: RTL and testbench
====================================

# display_scheduler

Time-shares the single 4-digit seven-segment display decoder between three value producers: the register-file debug tap, the program counter and the I/O output latch. It runs round-robin arbitration with a minimum dwell time per source, so each shown value stays readable. It captures the granted value with a one-cycle acknowledge and drives one stable 12-bit value and a source tag to the decoder.

## Interface
- `W`, 12, width of each displayed value; equals the decoder input width.
- `DWELL`, 50000000, minimum display cycles per granted value (1 s at 50 MHz); legal range 1 to 2^26-1.
- `BLANK_CYCLES`, 5000000, blanking length between sources; used only when the blanking feature is compiled in; legal range ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  3  request per source (bit 0 register tap, bit 1 PC, bit 2 I/O); held high until acked.
- `req_data`  in  3*W  source i value on bits [i*W +: W]; must be stable while `req[i]` is high.
- `hold`  in  1  freezes the dwell/blank counter and all grants while high.
- `ack`  out  3  one-hot one-cycle pulse: request i captured.
- `disp_value`  out  W  value to the BCD/7-seg decoder.
- `disp_src`  out  2  index of the source being shown (0..2).
- `disp_valid`  out  1  high once any value has been captured since reset.
- `disp_blank`  out  1  high during blanking; the decoder top level forces segments off.

## Operation
- States: IDLE (nothing captured), SHOW (dwell counting), EXPIRED (dwell done, still showing), BLANK (feature only).
- Reset: state IDLE; `disp_value`=0, `disp_src`=0, `disp_valid`=0, `ack`=0, `disp_blank`=0, counter=0, round-robin pointer = source 0 highest priority. A reset mid-dwell or mid-blank discards everything; pending requests are re-arbitrated from IDLE.
- Arbitration: among asserted `req` bits, pick the first at or after the pointer (modulo 3). After a grant, the pointer = granted+1 mod 3. A lone requester may be granted back-to-back.
- Capture edge (grant): `disp_value`←`req_data[i]`, `disp_src`←i, `disp_valid`←1, `ack[i]` high for exactly the following cycle, counter←DWELL-1, state→SHOW.
- IDLE or EXPIRED with any `req` (and `hold` low): capture on that edge.
- SHOW: counter decrements each cycle `hold` is low. At counter==0 with `hold` low: if any `req` is pending, switch (capture, or BLANK when the feature is on); otherwise go to EXPIRED.
- Requests arriving during SHOW are not preemptive; they wait for the dwell to expire.
- `req[i]` low with `ack[i]` not yet pulsed is a withdrawal; no error.
- A request still high during the `ack` cycle is not re-granted on that edge (state is SHOW).
- `hold` high: no counter change, no grant, no state change; outputs are frozen.

## Timing
- Grant latency from IDLE/EXPIRED: `req` high before edge k → `disp_value` and `ack` valid after edge k (1 cycle).
- Displayed time per value ≥ DWELL cycles, +BLANK_CYCLES when blanking is enabled, +hold cycles.
- With DWELL=1: SHOW lasts 1 cycle, so a continuous three-source request rotates every cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro `DISPLAY_SCHED_BLANK_EN`.
- Defined: at dwell expiry with a pending request, go to BLANK with counter←BLANK_CYCLES-1 and `disp_blank`=1, keeping `disp_value`/`disp_src`. At counter==0 (hold low), `disp_blank`←0 and arbitration runs on that edge. If no request remains, go to EXPIRED with the old value.
- Not defined: no BLANK state; `disp_blank` tied 0; switching is direct.

## Test plan
- Reset, then `req`=001 with data 0x123 → after 1 edge, `disp_value`=0x123, `disp_src`=0, `ack`=001 for one cycle, `disp_valid`=1.
- DWELL=4, `req`=111 held (each drops after its ack) → grants 0,1,2 spaced exactly 4 cycles apart; data 0x00A/0x00B/0x00C shown in order.
- DWELL=4, source 1 requests 2 cycles into source 0's dwell → no change until the counter expires, then `disp_src`=1 on the following edge.
- DWELL=4, assert `hold` for 3 cycles mid-dwell → switch delayed exactly 3 cycles; `ack` is not pulsed while hold is high.
- Assert `reset` mid-dwell with `req`=010 pending → all outputs return to reset values; source 1 is granted on the first edge after reset releases.
- With `DISPLAY_SCHED_BLANK_EN`, DWELL=4, BLANK_CYCLES=2 → `disp_blank`=1 for 2 cycles between sources; without the macro, `disp_blank` stays 0.

Source files
------------

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin time-sharing of the 7-seg decoder with minimum dwell
// Optional inter-source blanking is compiled in with DISPLAY_SCHED_BLANK_EN.
module display_scheduler #(
  parameter int W            = 12,
  parameter int DWELL        = 50000000,
  parameter int BLANK_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [3*W-1:0]   req_data,
  input  logic             hold,
  output logic [2:0]       ack,
  output logic [W-1:0]     disp_value,
  output logic [1:0]       disp_src,
  output logic             disp_valid,
  output logic             disp_blank
);

  localparam int CW = $clog2((DWELL > BLANK_CYCLES ? DWELL : BLANK_CYCLES) + 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
`ifdef DISPLAY_SCHED_BLANK_EN
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, SHOW, EXPIRED, BLANK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [2:0]    ack_q, ack_d;
  logic [W-1:0]  value_q, value_d;
  logic [1:0]    src_q, src_d;
  logic          valid_q, valid_d;
  logic          blank_q, blank_d;
  logic [1:0]    pick;
  logic          do_cap;

  // First asserted request at or after the pointer, wrapping modulo 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] s;
    rr_pick = p;
    for (int k = 2; k >= 0; k--) begin
      s = {1'b0, p} + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (r[s[1:0]]) rr_pick = s[1:0];
    end
  endfunction

  assign pick = rr_pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ack_d   = 3'b000;
    value_d = value_q;
    src_d   = src_q;
    valid_d = valid_q;
    blank_d = blank_q;
    do_cap  = 1'b0;
    if (!hold) begin
      case (state_q)
        IDLE, EXPIRED: if (|req) do_cap = 1'b1;
        SHOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (|req) begin
`ifdef DISPLAY_SCHED_BLANK_EN
            state_d = BLANK;
            cnt_d   = BLANK_LOAD;
            blank_d = 1'b1;
`else
            do_cap  = 1'b1;
`endif
          end else begin
            state_d = EXPIRED;
          end
        end
`ifdef DISPLAY_SCHED_BLANK_EN
        BLANK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            blank_d = 1'b0;
            if (|req) do_cap = 1'b1;
            else      state_d = EXPIRED;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    if (do_cap) begin
      value_d = req_data[int'(pick)*W +: W];
      src_d   = pick;
      valid_d = 1'b1;
      ack_d   = 3'b001 << pick;
      cnt_d   = DWELL_LOAD;
      state_d = SHOW;
      ptr_d   = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd0;
      ack_q   <= 3'b000;
      value_q <= '0;
      src_q   <= 2'd0;
      valid_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      value_q <= value_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
    end
  end

  assign ack        = ack_q;
  assign disp_value = value_q;
  assign disp_src   = src_q;
  assign disp_valid = valid_q;
  assign disp_blank = blank_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed self-checking bench for display_scheduler
// Expected timing follows DISPLAY_SCHED_BLANK_EN when defined.
module tb_display_scheduler;

  localparam int W = 12;
`ifdef DISPLAY_SCHED_BLANK_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     req;
  logic [3*W-1:0] req_data;
  logic           hold;
  logic [2:0]     ack;
  logic [W-1:0]   disp_value;
  logic [1:0]     disp_src;
  logic           disp_valid;
  logic           disp_blank;

  int total  = 0;
  int passed = 0;

  display_scheduler #(.W(W), .DWELL(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .hold(hold),
    .ack(ack), .disp_value(disp_value), .disp_src(disp_src),
    .disp_valid(disp_valid), .disp_blank(disp_blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    hold  = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
    req_data = {d2, d1, d0};
  endtask

  initial begin
    reset = 1'b1; req = 3'b000; hold = 1'b0; req_data = '0;
    // reset values and first capture
    step(2);
    check("rst_value", 32'(disp_value), 32'h0);
    check("rst_src",   32'(disp_src),   32'h0);
    check("rst_valid", 32'(disp_valid), 32'h0);
    check("rst_ack",   32'(ack),        32'h0);
    check("rst_blank", 32'(disp_blank), 32'h0);
    reset = 1'b0;
    set_data(12'h123, 12'h000, 12'h000);
    req = 3'b001;
    step(1);
    check("cap_value", 32'(disp_value), 32'h123);
    check("cap_src",   32'(disp_src),   32'h0);
    check("cap_ack",   32'(ack),        32'h1);
    check("cap_valid", 32'(disp_valid), 32'h1);
    req = 3'b000;
    step(1);
    check("cap_ack_drop", 32'(ack), 32'h0);
    step(6);
    check("exp_value", 32'(disp_value), 32'h123);
    check("exp_valid", 32'(disp_valid), 32'h1);

    // three-source rotation spaced by the dwell
    do_reset();
    set_data(12'h00A, 12'h00B, 12'h00C);
    req = 3'b111;
    step(1);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rot_src%0d", s),   32'(disp_src),   32'(s));
      check($sformatf("rot_val%0d", s),   32'(disp_value), 32'(12'h00A + s));
      check($sformatf("rot_ack%0d", s),   32'(ack),        32'(1 << s));
      req[s] = 1'b0;
      step(1);
      check($sformatf("rot_ackoff%0d", s), 32'(ack), 32'h0);
      step(2 + BL);
      check($sformatf("rot_hold%0d", s), 32'(disp_src), 32'(s));
      step(1);
    end

    // late request waits for dwell expiry
    do_reset();
    set_data(12'h111, 12'h222, 12'h000);
    req = 3'b001;
    step(1);
    check("late_src0", 32'(disp_src), 32'h0);
    req = 3'b000;
    step(2);
    req = 3'b010;
    step(1 + BL);
    check("late_wait", 32'(disp_src), 32'h0);
    check("late_noack", 32'(ack), 32'h0);
    step(1);
    check("late_src1", 32'(disp_src),   32'h1);
    check("late_val1", 32'(disp_value), 32'h222);
    check("late_ack1", 32'(ack),        32'h2);

    // hold freezes dwell for exactly its length
    do_reset();
    req = 3'b001;
    step(1);
    req = 3'b000;
    step(1);
    req  = 3'b010;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("hold_ack%0d", i), 32'(ack),      32'h0);
      check($sformatf("hold_src%0d", i), 32'(disp_src), 32'h0);
    end
    hold = 1'b0;
    step(2 + BL);
    check("hold_late", 32'(disp_src), 32'h0);
    step(1);
    check("hold_src1", 32'(disp_src), 32'h1);
    check("hold_ack1", 32'(ack),      32'h2);

    // reset mid-dwell, pending source re-arbitrated
    do_reset();
    set_data(12'h0AA, 12'h0BB, 12'h0CC);
    req = 3'b001;
    step(1);
    req = 3'b010;
    step(1);
    reset = 1'b1;
    step(1);
    check("mid_rst_value", 32'(disp_value), 32'h0);
    check("mid_rst_valid", 32'(disp_valid), 32'h0);
    check("mid_rst_ack",   32'(ack),        32'h0);
    check("mid_rst_src",   32'(disp_src),   32'h0);
    reset = 1'b0;
    step(1);
    check("post_rst_src", 32'(disp_src),   32'h1);
    check("post_rst_val", 32'(disp_value), 32'h0BB);
    check("post_rst_ack", 32'(ack),        32'h2);

    // withdrawal before grant, then lone requester after pointer wrap
    req = 3'b100;
    step(1);
    req = 3'b000;
    step(6);
    check("wd_src", 32'(disp_src), 32'h1);
    check("wd_ack", 32'(ack),      32'h0);
    req = 3'b010;
    step(1);
    check("lone_ack", 32'(ack),      32'h2);
    check("lone_src", 32'(disp_src), 32'h1);

    // blanking between sources
    do_reset();
    req = 3'b001;
    step(1);
    req = 3'b010;
    step(3);
    check("blk_pre", 32'(disp_blank), 32'h0);
    step(1);
`ifdef DISPLAY_SCHED_BLANK_EN
    check("blk_on0",  32'(disp_blank), 32'h1);
    check("blk_src0", 32'(disp_src),   32'h0);
    step(1);
    check("blk_on1",  32'(disp_blank), 32'h1);
    step(1);
    check("blk_off",  32'(disp_blank), 32'h0);
    check("blk_src1", 32'(disp_src),   32'h1);
`else
    check("blk_none", 32'(disp_blank), 32'h0);
    check("blk_src1", 32'(disp_src),   32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
